// File: rtl/mul_tree_pkg.sv
// Shared types and helpers for the pipelined shift-and-add multiplier.
// Tree depth, default latency and the per-transaction operand mode.
package mul_tree_pkg;

  typedef enum logic {
    MUL_UNSIGNED = 1'b0,
    MUL_SIGNED   = 1'b1
  } mul_mode_e;

  function automatic int tree_levels(input int width);
    return $clog2(width);
  endfunction

  localparam int DEF_WIDTH = 8;
  // One partial-product stage followed by one register per tree level
  localparam int LAT       = 1 + tree_levels(DEF_WIDTH);

endpackage

// File: rtl/mul_tree_add_stage.sv
// One registered level of the adder tree: sums adjacent pairs of its inputs.
// Valid and tag ride along; the whole stage holds when the pipe is stalled.
module mul_tree_add_stage import mul_tree_pkg::*; #(
  parameter int W2    = 16,
  parameter int N_IN  = 8,
  parameter int TAG_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          advance,
  input  logic                          vld_in,
  input  logic [TAG_W-1:0]              tag_in,
  input  logic [N_IN-1:0][W2-1:0]       sum_in,
  output logic                          vld_out,
  output logic [TAG_W-1:0]              tag_out,
  output logic [N_IN/2-1:0][W2-1:0]     sum_out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_out <= 1'b0;
      tag_out <= '0;
      sum_out <= '0;
    end else if (advance) begin
      vld_out <= vld_in;
      tag_out <= tag_in;
      // Carries out of the MSB drop naturally: result is mod 2^W2
      for (int j = 0; j < N_IN/2; j++)
        sum_out[j] <= sum_in[2*j] + sum_in[2*j+1];
    end
  end

endmodule

// File: rtl/mul_tree_pipe.sv
// Pipelined shift-and-add multiplier: registered partial products feeding a
// registered binary adder tree, with valid/ready and a per-transaction sign mode.
module mul_tree_pipe import mul_tree_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int W2     = 2*WIDTH;
  localparam int LEVELS = tree_levels(WIDTH);

  logic                     advance;
  logic [LEVELS:0]          vld_pipe;
  logic                     vld_s0;
  logic [TAG_W-1:0]         tag_s0;
  logic [WIDTH-1:0][W2-1:0] pp_d, pp_q;
  logic [W2-1:0]            a_ext;
  mul_mode_e                mode;

  // A stage may only move when the output slot is empty or being drained
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  assign mode  = mul_mode_e'(in_signed);
  assign a_ext = (mode == MUL_SIGNED) ? {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand}
                                      : {{WIDTH{1'b0}}, multiplicand};

  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH; i++)
      if (multiplier[i]) pp_d[i] = a_ext << i;
    // The multiplier MSB carries weight -2^(WIDTH-1) in two's complement
    if (mode == MUL_SIGNED) pp_d[WIDTH-1] = -pp_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_s0 <= 1'b0;
      tag_s0 <= '0;
      pp_q   <= '0;
    end else if (advance) begin
      vld_s0 <= in_valid;
      tag_s0 <= in_tag;
      pp_q   <= pp_d;
    end
  end

  assign vld_pipe[0] = vld_s0;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN = WIDTH >> l;
    logic                      vld;
    logic [TAG_W-1:0]          tag;
    logic [N_IN/2-1:0][W2-1:0] sum;

    if (l == 0) begin : g_first
      mul_tree_add_stage #(.W2(W2), .N_IN(N_IN), .TAG_W(TAG_W)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance),
        .vld_in  (vld_s0),
        .tag_in  (tag_s0),
        .sum_in  (pp_q),
        .vld_out (vld),
        .tag_out (tag),
        .sum_out (sum)
      );
    end else begin : g_next
      mul_tree_add_stage #(.W2(W2), .N_IN(N_IN), .TAG_W(TAG_W)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance),
        .vld_in  (g_lvl[l-1].vld),
        .tag_in  (g_lvl[l-1].tag),
        .sum_in  (g_lvl[l-1].sum),
        .vld_out (vld),
        .tag_out (tag),
        .sum_out (sum)
      );
    end

    assign vld_pipe[l+1] = vld;
  end

  assign out_valid = vld_pipe[LEVELS];
  assign product   = g_lvl[LEVELS-1].sum[0];
  assign out_tag   = g_lvl[LEVELS-1].tag;

endmodule

// File: tb/tb_mul_tree_pipe.sv
// Directed and scoreboard bench for mul_tree_pipe at WIDTH=8, plus a random
// regression across WIDTH=4/16/32 instances.
module tb_mul_tree_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  mcand, mplier;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] product;

  logic            p_valid, p_ready;
  logic [2:0][31:0] p_a, p_b;
  logic [2:0]      p_signed, p_tag, p_otag, p_ovalid, p_iready;
  logic [2:0][63:0] p_prod;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_tree_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .multiplicand(mcand), .multiplier(mplier), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .out_tag(out_tag)
  );

  mul_tree_pipe #(.WIDTH(4), .TAG_W(1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(p_valid), .in_ready(p_iready[0]),
    .in_signed(p_signed[0]), .multiplicand(p_a[0][3:0]), .multiplier(p_b[0][3:0]),
    .in_tag(p_tag[0:0]), .out_valid(p_ovalid[0]), .out_ready(p_ready),
    .product(p_prod[0][7:0]), .out_tag(p_otag[0:0])
  );

  mul_tree_pipe #(.WIDTH(16), .TAG_W(1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(p_valid), .in_ready(p_iready[1]),
    .in_signed(p_signed[1]), .multiplicand(p_a[1][15:0]), .multiplier(p_b[1][15:0]),
    .in_tag(p_tag[1:1]), .out_valid(p_ovalid[1]), .out_ready(p_ready),
    .product(p_prod[1][31:0]), .out_tag(p_otag[1:1])
  );

  mul_tree_pipe #(.WIDTH(32), .TAG_W(1)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(p_valid), .in_ready(p_iready[2]),
    .in_signed(p_signed[2]), .multiplicand(p_a[2]), .multiplier(p_b[2]),
    .in_tag(p_tag[2:2]), .out_valid(p_ovalid[2]), .out_ready(p_ready),
    .product(p_prod[2]), .out_tag(p_otag[2:2])
  );

  // Reference: extend both operands to 64 bits and multiply; low 2w bits are exact
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [63:0] ax, bx, m;
    for (int k = 0; k < 64; k++) begin
      ax[k] = (k < w) ? a[k] : (s & a[w-1]);
      bx[k] = (k < w) ? b[k] : (s & b[w-1]);
    end
    m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
    return (ax * bx) & m;
  endfunction

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [3:0] t, output logic [15:0] prod,
                         output logic [3:0] tg, output int lat);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; mcand = a; mplier = b; in_signed = s; in_tag = t;
    lat = -1; prod = '0; tg = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = c; prod = product; tg = out_tag;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_signed = 1'b0;
    mcand = '0; mplier = '0; in_tag = '0;
    p_valid = 1'b0; p_ready = 1'b1; p_a = '0; p_b = '0; p_signed = '0; p_tag = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || product !== 16'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b product=%h out_tag=%h in_ready=%b, want 0 0000 0 1",
               out_valid, product, out_tag, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_unsigned_max();
    logic [15:0] p; logic [3:0] t; int lat;
    run_one(8'hFF, 8'hFF, 1'b0, 4'd3, p, t, lat);
    checks++;
    if (p !== 16'hFE01 || t !== 4'd3 || lat != 4) begin
      errors++;
      $display("FAIL unsigned_max: product=%h tag=%0d lat=%0d, want fe01 3 4", p, t, lat);
    end
  endtask

  task automatic test_modes();
    logic [7:0]  va [7] = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h00, 8'h80};
    logic [7:0]  vb [7] = '{8'h80, 8'h05, 8'h05, 8'hFF, 8'h80, 8'hFF, 8'h80};
    logic        vs [7] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
    logic [15:0] ve [7] = '{16'h4000, 16'hFFFB, 16'h04FB, 16'h0001, 16'hC080, 16'h0000, 16'h4000};
    logic [15:0] p; logic [3:0] t; int lat;
    for (int k = 0; k < 7; k++) begin
      run_one(va[k], vb[k], vs[k], 4'(k + 5), p, t, lat);
      checks++;
      if (p !== ve[k] || t !== 4'(k + 5) || lat != 4) begin
        errors++;
        $display("FAIL mode_vec%0d: %h*%h s=%b product=%h tag=%0d lat=%0d, want %h %0d 4",
                 k, va[k], vb[k], vs[k], p, t, lat, ve[k], k + 5);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_p [16];
    logic [3:0]  exp_t [16];
    int got = 0;
    for (int cyc = 0; cyc < 16 + 12; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (cyc < 16) begin
        in_valid = 1'b1; mcand = 8'($urandom); mplier = 8'($urandom);
        in_signed = cyc[0]; in_tag = 4'(cyc);
        exp_p[cyc] = 16'(ref_mul(8, {24'd0, mcand}, {24'd0, mplier}, in_signed));
        exp_t[cyc] = in_tag;
      end else in_valid = 1'b0;
      #1;
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready: cyc=%0d in_ready=%b, want 1", cyc, in_ready);
        end
      end
      if (out_valid) begin
        checks++;
        if (got >= 16) begin
          errors++; $display("FAIL b2b_extra: cyc=%0d unexpected result %h", cyc, product);
        end else if (product !== exp_p[got] || out_tag !== exp_t[got] || cyc - got != 4) begin
          errors++;
          $display("FAIL b2b_item%0d: product=%h tag=%0d lat=%0d, want %h %0d 4",
                   got, product, out_tag, cyc - got, exp_p[got], exp_t[got]);
        end
        got++;
      end
    end
    checks++;
    if (got != 16) begin
      errors++; $display("FAIL b2b_count: got %0d results, want 16", got);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  ia [8], ib [8];
    logic [15:0] exp_p [8];
    logic [15:0] p0; logic [3:0] t0;
    int nidx = 0, got = 0;
    for (int k = 0; k < 8; k++) begin
      ia[k] = 8'(8'h31 + 8'(k * 23)); ib[k] = 8'(8'h0B + 8'(k * 37));
      exp_p[k] = 16'(ref_mul(8, {24'd0, ia[k]}, {24'd0, ib[k]}, k[1]));
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      mcand = ia[nidx]; mplier = ib[nidx]; in_signed = nidx[1]; in_tag = 4'(nidx);
      #1;
      if (in_ready) nidx++;
      else break;
    end
    checks++;
    if (nidx != 4) begin
      errors++; $display("FAIL bp_fill: accepted %0d before stall, want 4", nidx);
    end
    p0 = product; t0 = out_tag;
    checks++;
    if (p0 !== exp_p[0] || t0 !== 4'd0) begin
      errors++; $display("FAIL bp_head: product=%h tag=%0d, want %h 0", p0, t0, exp_p[0]);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || product !== p0 || out_tag !== t0) begin
        errors++;
        $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b product=%h tag=%0d, want 0 1 %h %0d",
                 c, in_ready, out_valid, product, out_tag, p0, t0);
      end
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (nidx < 8) begin
        in_valid = 1'b1; mcand = ia[nidx]; mplier = ib[nidx]; in_signed = nidx[1]; in_tag = 4'(nidx);
      end else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        checks++;
        if (got >= nidx || got >= 8) begin
          errors++; $display("FAIL bp_dup: unexpected result %h tag=%0d", product, out_tag);
        end else if (product !== exp_p[got] || out_tag !== 4'(got)) begin
          errors++;
          $display("FAIL bp_item%0d: product=%h tag=%0d, want %h %0d",
                   got, product, out_tag, exp_p[got], got);
        end
        got++;
      end
      if (in_valid && in_ready) nidx++;
    end
    checks++;
    if (got != 8 || nidx != 8) begin
      errors++; $display("FAIL bp_count: results=%0d accepted=%0d, want 8 8", got, nidx);
    end
  endtask

  task automatic test_reset_midstream();
    int ghosts = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; mcand = 8'h11 + 8'(k); mplier = 8'h22; in_signed = 1'b0;
      in_tag = 4'(k + 9);
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || product !== 16'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b product=%h tag=%h in_ready=%b, want 0 0000 0 1",
               out_valid, product, out_tag, in_ready);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) ghosts++;
    end
    checks++;
    if (ghosts != 0) begin
      errors++; $display("FAIL mid_reset_ghost: %0d results after reset, want 0", ghosts);
    end
  endtask

  task automatic test_param_regress();
    localparam int NP = 20;
    int          wl [3] = '{4, 16, 32};
    int          le [3] = '{3, 5, 6};
    logic [63:0] pexp [3][NP];
    int          got [3] = '{0, 0, 0};
    logic [63:0] m;
    for (int cyc = 0; cyc < NP + 12; cyc++) begin
      @(negedge clk);
      p_ready = 1'b1;
      if (cyc < NP) begin
        p_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
          if (cyc == 0) begin
            p_a[i] = 32'hFFFF_FFFF >> (32 - wl[i]); p_b[i] = p_a[i]; p_signed[i] = 1'b0;
          end else if (cyc == 1) begin
            p_a[i] = 32'd1 << (wl[i] - 1); p_b[i] = p_a[i]; p_signed[i] = 1'b1;
          end else begin
            p_a[i] = $urandom >> (32 - wl[i]); p_b[i] = $urandom >> (32 - wl[i]);
            p_signed[i] = 1'($urandom_range(0, 1));
          end
          p_tag[i] = cyc[0];
          pexp[i][cyc] = ref_mul(wl[i], p_a[i], p_b[i], p_signed[i]);
        end
      end else p_valid = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
        m = (wl[i] == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*wl[i])) - 64'd1);
        if (p_valid) begin
          checks++;
          if (p_iready[i] !== 1'b1) begin
            errors++; $display("FAIL w%0d_ready: cyc=%0d in_ready=%b, want 1", wl[i], cyc, p_iready[i]);
          end
        end
        if (p_ovalid[i]) begin
          checks++;
          if (got[i] >= NP) begin
            errors++; $display("FAIL w%0d_extra: unexpected result %h", wl[i], p_prod[i] & m);
          end else if ((p_prod[i] & m) !== pexp[i][got[i]] || p_otag[i] !== got[i][0] ||
                       cyc - got[i] != le[i]) begin
            errors++;
            $display("FAIL w%0d_item%0d: product=%h tag=%b lat=%0d, want %h %b %0d", wl[i], got[i],
                     p_prod[i] & m, p_otag[i], cyc - got[i], pexp[i][got[i]], got[i][0], le[i]);
          end
          got[i]++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] != NP) begin
        errors++; $display("FAIL w%0d_count: got %0d results, want %0d", wl[i], got[i], NP);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_param_regress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
